tlb_walk_arbiter: RTL and testbench
===================================

# tlb_walk_arbiter

Shares the single page-table walker between the instruction-side and data-side TLBs. Each TLB issues a one-cycle miss request carrying its virtual address and access type. The arbiter latches the request, grants the walker to one side at a time, and routes the walker's completion, fault or abort back to the owning TLB only. It sits inside the MMU between `itlb`/`dtlb` and the walker.

## Interface
- `ADDR_W`, 32: virtual address width.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_request`, `d_request` in 1 each: one-cycle miss request from the ITLB / DTLB.
- `i_virtual_address`, `d_virtual_address` in ADDR_W each: miss address.
- `i_rnw`, `d_rnw` in 1 each: read-not-write.
- `d_execute` in 1: data-side execute flag. The instruction side is always treated as execute=1.
- `i_abort`, `d_abort` in 1 each: requester abandons its miss.
- `ptw_request` out 1: one-cycle walk start.
- `ptw_virtual_address` out ADDR_W, `ptw_rnw` out 1, `ptw_execute` out 1: walk descriptor, held stable for the whole walk.
- `ptw_abort` out 1: cancels the walk in progress.
- `ptw_write_entry` in 1, `ptw_is_fault` in 1: walk result.
- `i_write_entry`, `d_write_entry` out 1 each: result forwarded to the owner.
- `i_is_fault`, `d_is_fault` out 1 each: fault forwarded to the owner.
- `busy` out 1: a walk is in progress.

## Operation
- Per-side pending register {valid, vaddr, rnw, execute}.
  - Loaded on `x_request`.
  - Cleared on that side's completion or fault, or on `x_abort`.
- A request arriving while that side is pending or owning is ignored; an assertion flags this case.
- State machine:
  - IDLE: if any pending, grant one side, assert `ptw_request` combinationally, register the owner, go to WALK.
  - WALK: on `ptw_write_entry` or `ptw_is_fault`, forward the result to the owner's `x_write_entry`/`x_is_fault` in the same cycle, clear the owner's pending, go to IDLE.
  - WALK with owner abort: assert `ptw_abort` in that cycle, suppress any simultaneous result to the owner, clear pending, go to IDLE.
- Abort of a non-owning pending side clears its pending only. The walker is unaffected.
- An abort arriving together with a new request on the same side: abort wins and nothing is latched.
- The grant is never given to a side whose abort is asserted in the same cycle.
- A completion in WALK and a new pending on the other side: IDLE is entered first, so the next grant occurs one cycle later.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, pending registers invalid.
  - Round-robin pointer = instruction side.
- Miss latency:
  - `x_request` at cycle N gives `ptw_request` at N+1 when the arbiter is idle.
  - Completion forwarding adds zero cycles.
- Descriptor outputs are driven from the owner's pending register during WALK and from the granted side in the IDLE grant cycle. They are 0 otherwise.
- `busy` = (state == WALK).
- A reset asserted mid-walk returns the arbiter to IDLE immediately. The walker is reset by the same `rst`.

## Configuration
- `TLB_WALK_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin. A one-bit pointer flips to the other side after each grant; when both sides are pending, the side the pointer selects wins.
  - Undefined: fixed priority, data side always wins. No pointer register.

## Structure
- `cva5_types` holds the shared definitions:
  - `walk_owner_t` enum {OWNER_I, OWNER_D}.
  - `walk_arb_state_t` {ARB_IDLE, ARB_WALK}.
  - `walk_req_t` packed struct {valid, vaddr, rnw, execute}.
- One sub-module, `walk_req_slot`, instantiated twice: the pending register with load, clear and abort logic.
- Arbitration and the FSM stay in the top level.

## Test plan
- Single I miss:
  - `i_request` with vaddr 0x4000_1000 at cycle 5 → `ptw_request` at 6 with `ptw_execute`=1.
  - `ptw_write_entry` at 12 → `i_write_entry` at 12, `d_write_entry` stays 0.
- Simultaneous misses: I 0x1000, D 0x2000 at the same cycle.
  - Round robin: I is served first, then D one cycle after I completes.
  - Fixed: D first.
- Owner abort: `d_abort` during the D walk → `ptw_abort` in the same cycle, no `d_write_entry` even if `ptw_write_entry` coincides, `busy`=0 next cycle.
- Non-owner abort: I pending while D walks, then `i_abort` → I pending cleared, no I grant after D completes.
- Fault: `ptw_is_fault` during the I walk → `i_is_fault` pulse, pending cleared, arbiter back to IDLE.
- Reset mid-walk: `rst` asserted during WALK → all outputs 0 immediately, a new request is served normally after release.

Source files
------------

// File: rtl/cva5_types.sv
// Shared definitions for the TLB page-table-walk arbiter.
//   walk_owner_t     : which TLB side owns (or is granted) the walker.
//   walk_arb_state_t : arbiter FSM state.
//   walk_req_t       : one side's pending miss {valid, vaddr, rnw, execute}.
//   pick_owner()     : grant selection shared by fixed and round-robin modes.
package cva5_types;

  // Address width carried by walk_req_t; the top-level ADDR_W must equal it.
  localparam int unsigned WALK_ADDR_W = 32;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } walk_owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WALK = 1'b1
  } walk_arb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [WALK_ADDR_W-1:0] vaddr;
    logic                   rnw;
    logic                   execute;
  } walk_req_t;

  // With both sides eligible the tie winner is taken; otherwise the single
  // eligible side. The caller only uses the result when one side is eligible.
  function automatic walk_owner_t pick_owner(input logic        i_elig,
                                             input logic        d_elig,
                                             input walk_owner_t tie_winner);
    if (i_elig && d_elig) return tie_winner;
    else if (i_elig)      return OWNER_I;
    else                  return OWNER_D;
  endfunction

  function automatic walk_owner_t other_side(input walk_owner_t side);
    return (side == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/walk_req_slot.sv
// Pending-miss register for one TLB side.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   request_i  : one-cycle miss request (ignored while already pending)
//   vaddr_i    : miss virtual address
//   rnw_i      : read-not-write
//   execute_i  : execute flag
//   abort_i    : requester abandons the miss; beats a simultaneous request
//   done_i     : the walk owned by this side completed or faulted
//   slot_o     : current pending descriptor
module walk_req_slot
  import cva5_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request_i,
  input  logic [WALK_ADDR_W-1:0] vaddr_i,
  input  logic                   rnw_i,
  input  logic                   execute_i,
  input  logic                   abort_i,
  input  logic                   done_i,
  output walk_req_t              slot_o
);

  walk_req_t slot_q, slot_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_d = slot_q;
    if (abort_i || done_i) begin
      slot_d.valid = 1'b0;
    end else if (request_i && !slot_q.valid) begin
      slot_d = '{valid: 1'b1, vaddr: vaddr_i, rnw: rnw_i, execute: execute_i};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_o = slot_q;

  // A second miss from a side that is still pending (or owning the walker)
  // is dropped; the TLB is not supposed to issue one.
  a_no_request_while_pending: assert property (
    @(posedge clk) disable iff (rst) !(request_i && slot_q.valid && !abort_i));

endmodule

// File: rtl/tlb_walk_arbiter.sv
// Arbitrates the single page-table walker between the ITLB and DTLB.
// Each side's miss is latched in a walk_req_slot; the FSM grants one side,
// drives the walk descriptor and routes result/fault/abort to the owner.
// Configuration macro:
//   TLB_WALK_ARB_ROUND_ROBIN_EN defined   : round-robin between the sides
//   TLB_WALK_ARB_ROUND_ROBIN_EN undefined : fixed priority, data side wins
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   i_/d_request, _virtual_address,
//   i_/d_rnw, d_execute               : one-cycle miss requests
//   i_/d_abort                        : requester abandons its miss
//   ptw_request                       : one-cycle walk start
//   ptw_virtual_address/_rnw/_execute : walk descriptor
//   ptw_abort                         : cancels the walk in progress
//   ptw_write_entry, ptw_is_fault     : walk result
//   i_/d_write_entry, i_/d_is_fault   : result forwarded to the owner
//   busy                              : a walk is in progress
module tlb_walk_arbiter
  import cva5_types::*;
#(
  parameter int unsigned ADDR_W = WALK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_request,
  input  logic [ADDR_W-1:0] i_virtual_address,
  input  logic              i_rnw,
  input  logic              i_abort,
  input  logic              d_request,
  input  logic [ADDR_W-1:0] d_virtual_address,
  input  logic              d_rnw,
  input  logic              d_execute,
  input  logic              d_abort,
  output logic              ptw_request,
  output logic [ADDR_W-1:0] ptw_virtual_address,
  output logic              ptw_rnw,
  output logic              ptw_execute,
  output logic              ptw_abort,
  input  logic              ptw_write_entry,
  input  logic              ptw_is_fault,
  output logic              i_write_entry,
  output logic              d_write_entry,
  output logic              i_is_fault,
  output logic              d_is_fault,
  output logic              busy
);

  walk_arb_state_t state_q, state_d;
  walk_owner_t     owner_q, owner_d;
  walk_owner_t     grant;
  walk_owner_t     tie_winner;
  walk_req_t       i_slot, d_slot;
  logic            i_eligible, d_eligible, grant_fire;
  logic            walk_result, i_done, d_done;

  walk_req_slot u_i_slot (
    .clk       (clk),
    .rst       (rst),
    .request_i (i_request),
    .vaddr_i   (i_virtual_address),
    .rnw_i     (i_rnw),
    .execute_i (1'b1),               // instruction fetches always execute
    .abort_i   (i_abort),
    .done_i    (i_done),
    .slot_o    (i_slot)
  );

  walk_req_slot u_d_slot (
    .clk       (clk),
    .rst       (rst),
    .request_i (d_request),
    .vaddr_i   (d_virtual_address),
    .rnw_i     (d_rnw),
    .execute_i (d_execute),
    .abort_i   (d_abort),
    .done_i    (d_done),
    .slot_o    (d_slot)
  );

  // A side aborting this cycle is never granted.
  assign i_eligible  = i_slot.valid && !i_abort;
  assign d_eligible  = d_slot.valid && !d_abort;
  assign grant_fire  = (state_q == ARB_IDLE) && (i_eligible || d_eligible);
  assign grant       = pick_owner(i_eligible, d_eligible, tie_winner);

  // Owner pending clears on result; an owner abort clears via the slot's
  // own abort input, so a coincident result is harmless there.
  assign walk_result = (state_q == ARB_WALK) && (ptw_write_entry || ptw_is_fault);
  assign i_done      = walk_result && (owner_q == OWNER_I);
  assign d_done      = walk_result && (owner_q == OWNER_D);

`ifdef TLB_WALK_ARB_ROUND_ROBIN_EN
  walk_owner_t rr_q, rr_d;

  // After each grant the pointer moves to the side that was not served.
  assign rr_d       = grant_fire ? other_side(grant) : rr_q;
  assign tie_winner = rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= OWNER_I;
    else     rr_q <= rr_d;
  end
`else
  assign tie_winner = OWNER_D;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    ptw_request         = 1'b0;
    ptw_abort           = 1'b0;
    ptw_virtual_address = '0;
    ptw_rnw             = 1'b0;
    ptw_execute         = 1'b0;
    i_write_entry       = 1'b0;
    d_write_entry       = 1'b0;
    i_is_fault          = 1'b0;
    d_is_fault          = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_fire) begin
          ptw_request = 1'b1;
          owner_d     = grant;
          state_d     = ARB_WALK;
          if (grant == OWNER_I) begin
            ptw_virtual_address = i_slot.vaddr;
            ptw_rnw             = i_slot.rnw;
            ptw_execute         = i_slot.execute;
          end else begin
            ptw_virtual_address = d_slot.vaddr;
            ptw_rnw             = d_slot.rnw;
            ptw_execute         = d_slot.execute;
          end
        end
      end

      ARB_WALK: begin
        if (owner_q == OWNER_I) begin
          ptw_virtual_address = i_slot.vaddr;
          ptw_rnw             = i_slot.rnw;
          ptw_execute         = i_slot.execute;
        end else begin
          ptw_virtual_address = d_slot.vaddr;
          ptw_rnw             = d_slot.rnw;
          ptw_execute         = d_slot.execute;
        end

        // Owner abort cancels the walk and swallows any same-cycle result.
        if ((owner_q == OWNER_I) ? i_abort : d_abort) begin
          ptw_abort = 1'b1;
          state_d   = ARB_IDLE;
        end else if (walk_result) begin
          if (owner_q == OWNER_I) begin
            i_write_entry = ptw_write_entry;
            i_is_fault    = ptw_is_fault;
          end else begin
            d_write_entry = ptw_write_entry;
            d_is_fault    = ptw_is_fault;
          end
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy = (state_q == ARB_WALK);

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
`timescale 1ns/1ps
module tb_tlb_walk_arbiter;

`ifdef TLB_WALK_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_request, d_request, i_rnw, d_rnw, d_execute, i_abort, d_abort;
  logic [31:0] i_virtual_address, d_virtual_address;
  logic        ptw_request, ptw_rnw, ptw_execute, ptw_abort;
  logic [31:0] ptw_virtual_address;
  logic        ptw_write_entry, ptw_is_fault;
  logic        i_write_entry, d_write_entry, i_is_fault, d_is_fault, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlb_walk_arbiter #(.ADDR_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_request           (i_request),
    .i_virtual_address   (i_virtual_address),
    .i_rnw               (i_rnw),
    .i_abort             (i_abort),
    .d_request           (d_request),
    .d_virtual_address   (d_virtual_address),
    .d_rnw               (d_rnw),
    .d_execute           (d_execute),
    .d_abort             (d_abort),
    .ptw_request         (ptw_request),
    .ptw_virtual_address (ptw_virtual_address),
    .ptw_rnw             (ptw_rnw),
    .ptw_execute         (ptw_execute),
    .ptw_abort           (ptw_abort),
    .ptw_write_entry     (ptw_write_entry),
    .ptw_is_fault        (ptw_is_fault),
    .i_write_entry       (i_write_entry),
    .d_write_entry       (d_write_entry),
    .i_is_fault          (i_is_fault),
    .d_is_fault          (d_is_fault),
    .busy                (busy)
  );

  // {ptw_request, ptw_abort, ptw_rnw, ptw_execute, i_we, d_we, i_flt, d_flt, busy, vaddr}
  function automatic logic [40:0] obs_vec();
    return {ptw_request, ptw_abort, ptw_rnw, ptw_execute, i_write_entry,
            d_write_entry, i_is_fault, d_is_fault, busy, ptw_virtual_address};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_request       = 1'b0;
    d_request       = 1'b0;
    i_abort         = 1'b0;
    d_abort         = 1'b0;
    ptw_write_entry = 1'b0;
    ptw_is_fault    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_virtual_address = '0;
    d_virtual_address = '0;
    i_rnw = 1'b0; d_rnw = 1'b0; d_execute = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    ptw_write_entry = 1'b1;    // must not leak through while in reset
    #2;
    total++;
    if (obs_vec() !== 41'h0) begin
      bad++; $display("FAIL reset_outputs: got=%h want=0", obs_vec());
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (obs_vec() !== 41'h0) begin
      bad++; $display("FAIL post_reset_idle: got=%h want=0", obs_vec());
    end
    tick();
  endtask

  task automatic test_single_i();
    do_reset();
    repeat (3) tick();
    i_request = 1'b1; i_virtual_address = 32'h4000_1000; i_rnw = 1'b1;
    @(negedge clk);
    total++;
    if (ptw_request !== 1'b0) begin
      bad++; $display("FAIL single_i_no_same_cycle_grant: ptw_request=%b want 0", ptw_request);
    end
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({ptw_request, ptw_execute, ptw_rnw, busy, ptw_virtual_address} !== {4'b1110, 32'h4000_1000}) begin
      bad++; $display("FAIL single_i_grant: req/exe/rnw/busy=%b%b%b%b addr=%h want 1110 40001000",
                      ptw_request, ptw_execute, ptw_rnw, busy, ptw_virtual_address);
    end
    tick();
    @(negedge clk);
    total++;
    if ({ptw_request, busy, ptw_virtual_address} !== {2'b01, 32'h4000_1000}) begin
      bad++; $display("FAIL single_i_walk_hold: req/busy=%b%b addr=%h want 01 40001000",
                      ptw_request, busy, ptw_virtual_address);
    end
    repeat (5) tick();
    ptw_write_entry = 1'b1;
    @(negedge clk);
    total++;
    if ({i_write_entry, d_write_entry, i_is_fault, busy} !== 4'b1001) begin
      bad++; $display("FAIL single_i_complete: iwe/dwe/ifl/busy=%b%b%b%b want 1001",
                      i_write_entry, d_write_entry, i_is_fault, busy);
    end
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({ptw_request, busy, i_write_entry} !== 3'b000) begin
      bad++; $display("FAIL single_i_back_idle: req/busy/iwe=%b%b%b want 000",
                      ptw_request, busy, i_write_entry);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [31:0] first_a, second_a;
    logic        first_is_i;
    first_is_i = RR;
    first_a    = first_is_i ? 32'h1000 : 32'h2000;
    second_a   = first_is_i ? 32'h2000 : 32'h1000;
    do_reset();
    i_request = 1'b1; i_virtual_address = 32'h1000; i_rnw = 1'b1;
    d_request = 1'b1; d_virtual_address = 32'h2000; d_rnw = 1'b0; d_execute = 1'b0;
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({ptw_request, ptw_virtual_address} !== {1'b1, first_a}) begin
      bad++; $display("FAIL sim_first_grant: req=%b addr=%h want 1 %h", ptw_request, ptw_virtual_address, first_a);
    end
    repeat (2) tick();
    ptw_write_entry = 1'b1;
    @(negedge clk);
    total++;
    if ({i_write_entry, d_write_entry, ptw_request} !== {first_is_i, !first_is_i, 1'b0}) begin
      bad++; $display("FAIL sim_first_complete: iwe/dwe/req=%b%b%b want %b%b0",
                      i_write_entry, d_write_entry, ptw_request, first_is_i, !first_is_i);
    end
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({ptw_request, busy, ptw_virtual_address} !== {2'b10, second_a}) begin
      bad++; $display("FAIL sim_second_grant: req/busy=%b%b addr=%h want 10 %h",
                      ptw_request, busy, ptw_virtual_address, second_a);
    end
    tick();
    ptw_write_entry = 1'b1;
    @(negedge clk);
    total++;
    if ({i_write_entry, d_write_entry} !== {!first_is_i, first_is_i}) begin
      bad++; $display("FAIL sim_second_complete: iwe/dwe=%b%b want %b%b",
                      i_write_entry, d_write_entry, !first_is_i, first_is_i);
    end
    tick(); idle_inputs();
  endtask

  task automatic test_owner_abort();
    do_reset();
    d_request = 1'b1; d_virtual_address = 32'h2222_0000; d_rnw = 1'b0; d_execute = 1'b0;
    tick(); idle_inputs();
    tick();
    d_abort = 1'b1; ptw_write_entry = 1'b1;
    @(negedge clk);
    total++;
    if ({ptw_abort, d_write_entry, i_write_entry, busy} !== 4'b1001) begin
      bad++; $display("FAIL owner_abort: abort/dwe/iwe/busy=%b%b%b%b want 1001",
                      ptw_abort, d_write_entry, i_write_entry, busy);
    end
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({busy, ptw_request, ptw_abort} !== 3'b000) begin
      bad++; $display("FAIL owner_abort_after: busy/req/abort=%b%b%b want 000", busy, ptw_request, ptw_abort);
    end
    tick();
  endtask

  task automatic test_non_owner_abort();
    do_reset();
    d_request = 1'b1; d_virtual_address = 32'h5555_0000; d_rnw = 1'b1; d_execute = 1'b1;
    tick(); idle_inputs();
    tick();
    i_request = 1'b1; i_virtual_address = 32'h3000;
    tick(); idle_inputs();
    i_abort = 1'b1;
    @(negedge clk);
    total++;
    if ({ptw_abort, busy, ptw_virtual_address} !== {2'b01, 32'h5555_0000}) begin
      bad++; $display("FAIL non_owner_abort_walker: abort/busy=%b%b addr=%h want 01 55550000",
                      ptw_abort, busy, ptw_virtual_address);
    end
    tick(); idle_inputs();
    ptw_write_entry = 1'b1;
    @(negedge clk);
    total++;
    if ({d_write_entry, i_write_entry} !== 2'b10) begin
      bad++; $display("FAIL non_owner_abort_d_done: dwe/iwe=%b%b want 10", d_write_entry, i_write_entry);
    end
    tick(); idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({ptw_request, busy} !== 2'b00) begin
        bad++; $display("FAIL non_owner_abort_no_grant: cycle=%0d req/busy=%b%b want 00", k, ptw_request, busy);
      end
      tick();
    end
  endtask

  task automatic test_fault();
    do_reset();
    i_request = 1'b1; i_virtual_address = 32'h0BAD_0000; i_rnw = 1'b0;
    tick(); idle_inputs();
    tick(); tick();
    ptw_is_fault = 1'b1;
    @(negedge clk);
    total++;
    if ({i_is_fault, i_write_entry, d_is_fault, d_write_entry} !== 4'b1000) begin
      bad++; $display("FAIL fault_forward: ifl/iwe/dfl/dwe=%b%b%b%b want 1000",
                      i_is_fault, i_write_entry, d_is_fault, d_write_entry);
    end
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({busy, ptw_request, i_is_fault} !== 3'b000) begin
      bad++; $display("FAIL fault_idle: busy/req/ifl=%b%b%b want 000", busy, ptw_request, i_is_fault);
    end
    tick();
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    i_request = 1'b1; i_virtual_address = 32'h7777_0000;
    tick(); idle_inputs();
    tick();
    rst = 1'b1; ptw_write_entry = 1'b1;
    #1;
    total++;
    if (obs_vec() !== 41'h0) begin
      bad++; $display("FAIL reset_mid_walk: got=%h want=0", obs_vec());
    end
    tick();
    rst = 1'b0; idle_inputs();
    d_request = 1'b1; d_virtual_address = 32'h0000_BEEF; d_rnw = 1'b0; d_execute = 1'b1;
    tick(); idle_inputs();
    @(negedge clk);
    total++;
    if ({ptw_request, ptw_execute, ptw_rnw, ptw_virtual_address} !== {3'b110, 32'h0000_BEEF}) begin
      bad++; $display("FAIL reset_then_serve: req/exe/rnw=%b%b%b addr=%h want 110 0000beef",
                      ptw_request, ptw_execute, ptw_rnw, ptw_virtual_address);
    end
    tick();
  endtask

  // Randomized traffic against a per-side model of the arbitration rules.
  task automatic test_random(input int cycles);
    logic        pv[2], prnw[2], px[2], rq[2], ab[2], done[2];
    logic [31:0] pa[2];
    logic        walk, nxt_walk, we, flt, el0, el1;
    int          own, ptr, g;
    logic        e_req, e_ab, e_rnw, e_x, e_iwe, e_dwe, e_if, e_df;
    logic [31:0] e_a;
    logic [40:0] exp_v, got_v;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0; pa[s] = '0; prnw[s] = 1'b0; px[s] = 1'b0;
    end
    walk = 1'b0; own = 0; ptr = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int s = 0; s < 2; s++) begin
        ab[s]   = ($urandom_range(15) == 0);
        rq[s]   = !pv[s] && ($urandom_range(3) == 0);
        done[s] = 1'b0;
      end
      we  = walk ? ($urandom_range(4) == 0) : ($urandom_range(19) == 0);
      flt = walk ? ($urandom_range(9) == 0) : 1'b0;
      i_request = rq[0]; d_request = rq[1]; i_abort = ab[0]; d_abort = ab[1];
      ptw_write_entry = we; ptw_is_fault = flt;
      i_virtual_address = $urandom; d_virtual_address = $urandom;
      i_rnw = 1'($urandom_range(1)); d_rnw = 1'($urandom_range(1)); d_execute = 1'($urandom_range(1));

      {e_req, e_ab, e_rnw, e_x, e_iwe, e_dwe, e_if, e_df} = '0;
      e_a = '0;
      nxt_walk = walk;
      if (!walk) begin
        el0 = pv[0] && !ab[0];
        el1 = pv[1] && !ab[1];
        if (el0 || el1) begin
          g = (el0 && el1) ? (RR ? ptr : 1) : (el1 ? 1 : 0);
          e_req = 1'b1; e_a = pa[g]; e_rnw = prnw[g]; e_x = px[g];
          nxt_walk = 1'b1; own = g; ptr = 1 - g;
        end
      end else begin
        e_a = pa[own]; e_rnw = prnw[own]; e_x = px[own];
        if (ab[own]) begin
          e_ab = 1'b1; nxt_walk = 1'b0;
        end else if (we || flt) begin
          if (own == 0) begin e_iwe = we; e_if = flt; end
          else          begin e_dwe = we; e_df = flt; end
          done[own] = 1'b1; nxt_walk = 1'b0;
        end
      end
      exp_v = {e_req, e_ab, e_rnw, e_x, e_iwe, e_dwe, e_if, e_df, walk, e_a};

      @(negedge clk);
      got_v = obs_vec();
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL random cycle=%0d: got=%h want=%h", c, got_v, exp_v);
      end

      for (int s = 0; s < 2; s++) begin
        if (ab[s] || done[s]) pv[s] = 1'b0;
        else if (rq[s] && !pv[s]) begin
          pv[s]   = 1'b1;
          pa[s]   = (s == 0) ? i_virtual_address : d_virtual_address;
          prnw[s] = (s == 0) ? i_rnw : d_rnw;
          px[s]   = (s == 0) ? 1'b1 : d_execute;
        end
      end
      walk = nxt_walk;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    i_virtual_address = '0; d_virtual_address = '0;
    i_rnw = 1'b0; d_rnw = 1'b0; d_execute = 1'b0;
    test_reset();
    test_single_i();
    test_simultaneous();
    test_owner_abort();
    test_non_owner_abort();
    test_fault();
    test_reset_mid_walk();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
